mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 36 +++
 rtl/mdu_datapath.sv | 71 +++++++
 rtl/mult_div_unit.sv | 100 ++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions: op encodings, latencies, FSM states.
// MDU_MADD_EN adds MADD to the set of ops that Start may launch.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    logic ok;
    ok = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    ok = ok || (op == OP_MADD);
`endif
    return ok;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational 64-bit result for mult/multu/div/divu (and madd when MDU_MADD_EN).
// wr_o low means HI/LO must keep their value (divide by zero, non-arith op).
module mdu_datapath
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        sdiv, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_res, r_res;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
  assign sdiv  = (op_i == OP_DIV);
  assign a_neg = sdiv & a_i[31];
  assign b_neg = sdiv & b_i[31];
  assign a_mag = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag = b_neg ? (32'd0 - b_i) : b_i;
  assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign q_res = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_res = a_neg ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i} + prod_s;
`endif

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    wr_o = 1'b0;
    case (op_i)
      OP_MULT: begin
        {hi_o, lo_o} = prod_s;
        wr_o = 1'b1;
      end
      OP_MULTU: begin
        {hi_o, lo_o} = prod_u;
        wr_o = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        hi_o = r_res;
        lo_o = q_res;
        wr_o = (b_i != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        {hi_o, lo_o} = acc;
        wr_o = 1'b1;
      end
`endif
      default: wr_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO; FSM, latency counter, registers.
// Optional MDU_MADD_EN enables MADD (signed multiply-accumulate into {HI,LO}).
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic        MoveWE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dp_hi, dp_lo;
  logic        dp_wr;

  mdu_datapath u_datapath (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (dp_hi),
    .lo_o (dp_lo),
    .wr_o (dp_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        // Any Start blocks a same-cycle move, even when the op itself is a no-op.
        if (Start) begin
          if (is_start_op(MDUOp)) begin
            state_d = S_RUN;
            op_d    = MDUOp;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_div_op(MDUOp) ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);
          end
        end else if (MoveWE) begin
          if (MDUOp == OP_MTHI) hi_d = A;
          else if (MDUOp == OP_MTLO) lo_d = A;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (dp_wr) begin
            hi_d = dp_hi;
            lo_d = dp_lo;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; expectations queued by the driver, checked by a monitor.
// Define MDU_MADD_EN for both bench and RTL to exercise MADD.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic        MoveWE;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDUOp  (MDUOp),
    .MoveWE (MoveWE),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic probe = 1'b0;

  localparam logic [3:0] MULT = 4'd0, MULTU = 4'd1, DIV = 4'd2, DIVU = 4'd3,
                         MTHI = 4'd4, MTLO = 4'd5, MADD = 4'd6;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: Busy falling edge or a probe request is an output event.
  initial begin
    int   busy_len;
    logic prev_busy;
    exp_t e;
    busy_len  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) busy_len++;
      if (prev_busy && Busy !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_busy: busy run of %0d cycles, expected none", busy_len);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".busy_cycles"}, 32'(busy_len), 32'(e.len));
          chk({e.name, ".HI"}, HI, e.hi);
          chk({e.name, ".LO"}, LO, e.lo);
        end
        busy_len = 0;
      end else if (probe) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL probe_queue: got empty queue, expected an entry");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".busy"}, {31'd0, Busy}, 32'd0);
          chk({e.name, ".HI"}, HI, e.hi);
          chk({e.name, ".LO"}, LO, e.lo);
        end
      end
      prev_busy = (Busy === 1'b1);
    end
  end

  task automatic push(input string nm, input int len, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = nm; e.len = len; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!Busy) begin done = 1; break; end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s.timeout: Busy still %b, expected 0 within 30 cycles", nm, Busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int len,
                       input logic [31:0] hi, input logic [31:0] lo);
    push(nm, len, hi, lo);
    start_op(op, a, b);
    wait_idle(nm);
  endtask

  task automatic move(input logic [3:0] op, input logic [31:0] a);
    MoveWE = 1'b1; MDUOp = op; A = a;
    @(posedge clk); #1;
    MoveWE = 1'b0;
  endtask

  task automatic probe_chk(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    push(nm, 0, hi, lo);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; MoveWE = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    probe_chk("reset", 32'h0, 32'h0);

    do_op("mult_neg", MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("mult_min", MULT, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
    do_op("divu_7_2", DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    do_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_m7_m2", DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'd3);
    do_op("divu_big", DIVU, 32'hFFFFFFFF, 32'h10, 10, 32'hF, 32'h0FFFFFFF);
    do_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    move(MTHI, 32'h12345678);
    move(MTLO, 32'h9ABCDEF0);
    probe_chk("mthi_mtlo", 32'h12345678, 32'h9ABCDEF0);

    // Divide by zero keeps HI/LO; a Start mid-run must not extend Busy.
    move(MTHI, 32'd5);
    move(MTLO, 32'd6);
    push("div_zero", 10, 32'd5, 32'd6);
    start_op(DIV, 32'd123, 32'd0);
    repeat (3) @(posedge clk);
    #1 start_op(MULT, 32'd9, 32'd9);
    wait_idle("div_zero");

    // Start with a non-start op in the same cycle as MoveWE: neither takes effect.
    Start = 1'b1; MoveWE = 1'b1; MDUOp = MTHI; A = 32'hDEADBEEF;
    @(posedge clk); #1;
    Start = 1'b0; MoveWE = 1'b0;
    probe_chk("start_vs_move", 32'd5, 32'd6);

    push("move_in_busy", 5, 32'd0, 32'd12);
    start_op(MULTU, 32'd3, 32'd4);
    @(posedge clk); #1;
    move(MTHI, 32'hAAAAAAAA);
    wait_idle("move_in_busy");

    start_op(4'd7, 32'd1, 32'd1);
    probe_chk("undef_op", 32'd0, 32'd12);

    push("reset_mid", 3, 32'd0, 32'd0);
    start_op(MULT, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    probe_chk("after_reset", 32'd0, 32'd0);
    do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);

    move(MTHI, 32'd0);
    move(MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    do_op("madd_carry", MADD, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    do_op("madd_neg", MADD, 32'hFFFFFFFF, 32'd1, 5, 32'd0, 32'hFFFFFFFF);
`else
    start_op(MADD, 32'd1, 32'd1);
    probe_chk("madd_off", 32'd0, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expected responses outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
